burst_rd_engine: RTL

BURST_RD_ENGINE -- requirements
Module: burst_rd_engine

---
 rtl/axi_rd_pkg.sv | 35 +++
 rtl/rd_burst_calc.sv | 31 +++
 rtl/burst_rd_engine.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/axi_rd_pkg.sv
// Shared types and helpers for the AXI burst read engine: FSM states,
// RRESP codes and the beat-width to ARSIZE conversion.
package axi_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_EXOKAY = 2'b01;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    function automatic logic [2:0] axsize_from_width(input int data_width);
        logic [2:0] size;
        size = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((8 << i) == data_width) size = 3'(i);
        end
        return size;
    endfunction

    function automatic logic rresp_is_err(input logic [1:0] rresp);
        logic is_err;
        case (rresp)
            RRESP_SLVERR, RRESP_DECERR: is_err = 1'b1;
            RRESP_OKAY, RRESP_EXOKAY:   is_err = 1'b0;
        endcase
        return is_err;
    endfunction

endpackage

// File: rtl/rd_burst_calc.sv
// Combinational burst sizing: beats in the next burst, its ARLEN, and the
// address / remaining count that follow once that burst is issued.
module rd_burst_calc
    import axi_rd_pkg::*;
#(
    parameter int ADDR_WIDTH  = 33,
    parameter int DATA_WIDTH  = 256,
    parameter int LEN_WIDTH   = 8,
    parameter int BURST_BEATS = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [CNT_WIDTH-1:0]  i_remaining,
    output logic [LEN_WIDTH:0]    o_n,
    output logic [LEN_WIDTH-1:0]  o_arlen,
    output logic [ADDR_WIDTH-1:0] o_next_addr,
    output logic [CNT_WIDTH-1:0]  o_next_remaining
);

    localparam int N_W  = LEN_WIDTH + 1;
    localparam int SIZE = int'(axsize_from_width(DATA_WIDTH));
    localparam logic [CNT_WIDTH-1:0] MAX_N = CNT_WIDTH'(BURST_BEATS);

    always_comb begin
        o_n              = (i_remaining >= MAX_N) ? N_W'(BURST_BEATS) : N_W'(i_remaining);
        o_arlen          = LEN_WIDTH'(o_n - N_W'(1));
        o_next_addr      = i_addr + (ADDR_WIDTH'(o_n) << SIZE);
        o_next_remaining = i_remaining - CNT_WIDTH'(o_n);
    end

endmodule

// File: rtl/burst_rd_engine.sv
// Splits a (start address, beat count) command into single-outstanding AXI
// INCR read bursts and forwards the read data as a zero-latency stream.
module burst_rd_engine
    import axi_rd_pkg::*;
#(
    parameter int ENGINE_ID   = 0,
    parameter int ADDR_WIDTH  = 33,
    parameter int DATA_WIDTH  = 256,
    parameter int ID_WIDTH    = 6,
    parameter int LEN_WIDTH   = 8,
    parameter int BURST_BEATS = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [CNT_WIDTH-1:0]  cmd_beats,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  m_axi_ARVALID,
    input  logic                  m_axi_ARREADY,
    output logic [ADDR_WIDTH-1:0] m_axi_ARADDR,
    output logic [ID_WIDTH-1:0]   m_axi_ARID,
    output logic [LEN_WIDTH-1:0]  m_axi_ARLEN,
    output logic [2:0]            m_axi_ARSIZE,
    output logic [1:0]            m_axi_ARBURST,
    output logic                  m_axi_ARLOCK,
    output logic [3:0]            m_axi_ARCACHE,
    output logic [2:0]            m_axi_ARPROT,
    output logic [3:0]            m_axi_ARQOS,
    output logic [3:0]            m_axi_ARREGION,
    input  logic                  m_axi_RVALID,
    output logic                  m_axi_RREADY,
    input  logic [DATA_WIDTH-1:0] m_axi_RDATA,
    input  logic                  m_axi_RLAST,
    input  logic [ID_WIDTH-1:0]   m_axi_RID,
    input  logic [1:0]            m_axi_RRESP
);

    localparam int N_W = LEN_WIDTH + 1;
    localparam logic [ID_WIDTH-1:0] AR_ID = ID_WIDTH'(ENGINE_ID);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]  r_remaining;
    logic [N_W-1:0]        r_burst_n;
    logic [N_W-1:0]        r_beat_cnt;
    logic                  r_sticky;

    logic [N_W-1:0]        w_n;
    logic [LEN_WIDTH-1:0]  w_arlen;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [CNT_WIDTH-1:0]  w_next_rem;
    logic                  w_in_data;
    logic                  w_beat;
    logic                  w_beat_is_n;
    logic                  w_burst_end;
    logic                  w_beat_err;

    rd_burst_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .BURST_BEATS(BURST_BEATS),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_calc (
        .i_addr          (r_addr),
        .i_remaining     (r_remaining),
        .o_n             (w_n),
        .o_arlen         (w_arlen),
        .o_next_addr     (w_next_addr),
        .o_next_remaining(w_next_rem)
    );

    // Gating with resetn makes the R-side outputs look like IDLE while reset is held.
    assign w_in_data   = resetn && (r_state == ST_DATA);
    assign w_beat      = w_in_data && m_axi_RVALID && out_ready;
    assign w_beat_is_n = ((r_beat_cnt + N_W'(1)) == r_burst_n);
    assign w_burst_end = m_axi_RLAST || w_beat_is_n;
    assign w_beat_err  = rresp_is_err(m_axi_RRESP) || (m_axi_RID != AR_ID)
                         || (m_axi_RLAST != w_beat_is_n);

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_burst_n   <= '0;
            r_beat_cnt  <= '0;
            r_sticky    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (cmd_valid) begin
                    r_addr      <= cmd_addr;
                    r_remaining <= cmd_beats;
                    r_sticky    <= 1'b0;
                end
                ST_ADDR: if (m_axi_ARREADY) begin
                    r_addr      <= w_next_addr;
                    r_remaining <= w_next_rem;
                    r_burst_n   <= w_n;
                    r_beat_cnt  <= '0;
                end
                ST_DATA: if (w_beat) begin
                    r_beat_cnt <= r_beat_cnt + N_W'(1);
                    if (w_beat_err) r_sticky <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: next state defaults to the current state first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (cmd_valid) w_state_nxt = (cmd_beats == '0) ? ST_DONE : ST_ADDR;
            ST_ADDR: if (m_axi_ARREADY) w_state_nxt = ST_DATA;
            ST_DATA: if (w_beat && w_burst_end)
                         w_state_nxt = (r_remaining != '0) ? ST_ADDR : ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
        endcase
    end

    assign cmd_ready = !resetn || (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign err       = done && r_sticky;

    assign out_valid    = w_in_data && m_axi_RVALID;
    assign out_data     = m_axi_RDATA;
    assign out_last     = w_in_data && m_axi_RLAST && (r_remaining == '0);
    assign m_axi_RREADY = w_in_data && out_ready;

    assign m_axi_ARVALID  = (r_state == ST_ADDR);
    assign m_axi_ARADDR   = r_addr;
    assign m_axi_ARLEN    = (r_state == ST_ADDR) ? w_arlen : '0;
    assign m_axi_ARID     = AR_ID;
    assign m_axi_ARSIZE   = axsize_from_width(DATA_WIDTH);
    assign m_axi_ARBURST  = 2'b01;
    assign m_axi_ARLOCK   = 1'b0;
    assign m_axi_ARCACHE  = 4'd0;
    assign m_axi_ARPROT   = 3'b010;
    assign m_axi_ARQOS    = 4'd0;
    assign m_axi_ARREGION = 4'd0;

endmodule
